// File: rtl/msrv32_load_store_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : msrv32_load_store_unit_if
// Brief    : Issue, data-memory and writeback signals of the load/store unit.
// Revision : 1.0
// ============================================================================
interface msrv32_load_store_unit_if;
    logic        req_valid_in;
    logic        req_ready_out;
    logic        req_is_store_in;
    logic [2:0]  funct3_in;
    logic [31:0] addr_in;
    logic [31:0] store_data_in;
    logic [4:0]  rd_addr_in;
    logic        dmem_req_out;
    logic        dmem_we_out;
    logic [31:0] dmem_addr_out;
    logic [31:0] dmem_wdata_out;
    logic [3:0]  dmem_wmask_out;
    logic        dmem_ack_in;
    logic [31:0] dmem_rdata_in;
    logic [4:0]  wb_rd_addr_out;
    logic        wb_wr_en_out;
    logic [31:0] wb_rd_out;
    logic        stall_out;
    logic        misaligned_out;

    // Environment side: issue logic, data memory and integer register file.
    modport master (
        output req_valid_in, req_is_store_in, funct3_in, addr_in, store_data_in, rd_addr_in,
        output dmem_ack_in, dmem_rdata_in,
        input  req_ready_out, dmem_req_out, dmem_we_out, dmem_addr_out, dmem_wdata_out,
        input  dmem_wmask_out, wb_rd_addr_out, wb_wr_en_out, wb_rd_out, stall_out, misaligned_out
    );

    // Load/store unit side.
    modport slave (
        input  req_valid_in, req_is_store_in, funct3_in, addr_in, store_data_in, rd_addr_in,
        input  dmem_ack_in, dmem_rdata_in,
        output req_ready_out, dmem_req_out, dmem_we_out, dmem_addr_out, dmem_wdata_out,
        output dmem_wmask_out, wb_rd_addr_out, wb_wr_en_out, wb_rd_out, stall_out, misaligned_out
    );
endinterface
`default_nettype wire

// File: rtl/msrv32_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : msrv32_load_store_unit
// Brief    : Stage-3 multi-cycle load/store unit with req/ack data-memory
//            handshake and single-cycle integer-file writeback.
//            Optional misalignment trap: MSRV32_LSU_MISALIGN_TRAP_EN.
// Revision : 1.0
// ============================================================================
module msrv32_load_store_unit (
    input  wire                        ms_riscv32_mp_clk_in,
    input  wire                        ms_riscv32_mp_rst_in,
    msrv32_load_store_unit_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_WB   = 2'd2
`ifdef MSRV32_LSU_MISALIGN_TRAP_EN
        ,
        ST_TRAP = 2'd3
`endif
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_is_store;
    logic [2:0]  r_funct3;
    logic [1:0]  r_addr_lo;
    logic [31:0] r_dmem_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wmask;
    logic [4:0]  r_rd;
    logic [31:0] r_wb_data;

    logic        w_accept;
    logic [31:0] w_st_wdata;
    logic [3:0]  w_st_wmask;
    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;
    logic [31:0] w_ld_data;
    logic        w_misaligned;

    assign w_accept = (r_state == ST_IDLE) && bus.req_valid_in;

    // Lane-replicated store data and strobes; loads present no strobes.
    always_comb begin
        w_st_wdata = 32'd0;
        w_st_wmask = 4'd0;
        if (bus.req_is_store_in) begin
            case (bus.funct3_in)
                3'b000: begin
                    w_st_wdata = {4{bus.store_data_in[7:0]}};
                    w_st_wmask = 4'b0001 << bus.addr_in[1:0];
                end
                3'b001: begin
                    w_st_wdata = {2{bus.store_data_in[15:0]}};
                    w_st_wmask = 4'b0011 << {bus.addr_in[1], 1'b0};
                end
                default: begin
                    w_st_wdata = bus.store_data_in;
                    w_st_wmask = 4'b1111;
                end
            endcase
        end
    end

`ifdef MSRV32_LSU_MISALIGN_TRAP_EN
    // Loads use funct3[1:0] as the width code; stores treat anything but SB/SH as SW.
    always_comb begin
        w_misaligned = 1'b0;
        if (bus.req_is_store_in) begin
            case (bus.funct3_in)
                3'b000:  w_misaligned = 1'b0;
                3'b001:  w_misaligned = bus.addr_in[0];
                default: w_misaligned = |bus.addr_in[1:0];
            endcase
        end else begin
            case (bus.funct3_in[1:0])
                2'b00:   w_misaligned = 1'b0;
                2'b01:   w_misaligned = bus.addr_in[0];
                default: w_misaligned = |bus.addr_in[1:0];
            endcase
        end
    end
`else
    assign w_misaligned = 1'b0;
`endif

    always_comb begin
        case (r_addr_lo)
            2'd0:    w_ld_byte = bus.dmem_rdata_in[7:0];
            2'd1:    w_ld_byte = bus.dmem_rdata_in[15:8];
            2'd2:    w_ld_byte = bus.dmem_rdata_in[23:16];
            default: w_ld_byte = bus.dmem_rdata_in[31:24];
        endcase
        w_ld_half = r_addr_lo[1] ? bus.dmem_rdata_in[31:16] : bus.dmem_rdata_in[15:0];
        case (r_funct3)
            3'b000:  w_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
            3'b001:  w_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
            3'b100:  w_ld_data = {24'd0, w_ld_byte};
            3'b101:  w_ld_data = {16'd0, w_ld_half};
            default: w_ld_data = bus.dmem_rdata_in;
        endcase
    end

    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.req_valid_in) begin
                    w_next = w_misaligned ?
`ifdef MSRV32_LSU_MISALIGN_TRAP_EN
                        ST_TRAP
`else
                        ST_BUSY
`endif
                        : ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (bus.dmem_ack_in) begin
                    w_next = r_is_store ? ST_IDLE : ST_WB;
                end
            end
            ST_WB:   w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            r_is_store  <= 1'b0;
            r_funct3    <= 3'd0;
            r_addr_lo   <= 2'd0;
            r_dmem_addr <= 32'd0;
            r_wdata     <= 32'd0;
            r_wmask     <= 4'd0;
            r_rd        <= 5'd0;
            r_wb_data   <= 32'd0;
        end else begin
            if (w_accept) begin
                r_is_store  <= bus.req_is_store_in;
                r_funct3    <= bus.funct3_in;
                r_addr_lo   <= bus.addr_in[1:0];
                r_dmem_addr <= {bus.addr_in[31:2], 2'b00};
                r_wdata     <= w_st_wdata;
                r_wmask     <= w_st_wmask;
                r_rd        <= bus.rd_addr_in;
            end
            if ((r_state == ST_BUSY) && bus.dmem_ack_in && !r_is_store) begin
                r_wb_data <= w_ld_data;
            end
        end
    end

    // Handshake strobes decode from state so reset drops them asynchronously.
    assign bus.req_ready_out  = (r_state == ST_IDLE);
    assign bus.dmem_req_out   = (r_state == ST_BUSY);
    assign bus.stall_out      = (r_state != ST_IDLE);
    assign bus.dmem_we_out    = r_is_store;
    assign bus.dmem_addr_out  = r_dmem_addr;
    assign bus.dmem_wdata_out = r_wdata;
    assign bus.dmem_wmask_out = r_wmask;
    assign bus.wb_rd_addr_out = r_rd;
    assign bus.wb_wr_en_out   = (r_state == ST_WB) && (r_rd != 5'd0);
    assign bus.wb_rd_out      = r_wb_data;
`ifdef MSRV32_LSU_MISALIGN_TRAP_EN
    assign bus.misaligned_out = (r_state == ST_TRAP);
`else
    assign bus.misaligned_out = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_msrv32_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_msrv32_load_store_unit
// Brief    : Directed self-checking bench for msrv32_load_store_unit.
// Revision : 1.0
// ============================================================================
module tb_msrv32_load_store_unit;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    int   n_fail;

    msrv32_load_store_unit_if bus ();

    msrv32_load_store_unit dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst),
        .bus                  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge with the unit idle; returns at the falling edge of the first BUSY cycle.
    task automatic issue(input string tag, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] data, input logic [4:0] rd);
        bus.req_valid_in    = 1'b1;
        bus.req_is_store_in = st;
        bus.funct3_in       = f3;
        bus.addr_in         = addr;
        bus.store_data_in   = data;
        bus.rd_addr_in      = rd;
        chk({tag, ".ready"}, {31'd0, bus.req_ready_out}, 32'd1);
        @(negedge clk);
        bus.req_valid_in  = 1'b0;
        bus.addr_in       = 32'hFFFF_FFFF;
        bus.store_data_in = 32'h0;
        bus.rd_addr_in    = 5'd0;
    endtask

    task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [4:0] rd, input logic [31:0] rdata, input int waits,
                            input logic [31:0] exp_addr, input logic [31:0] exp_data,
                            input logic exp_we);
        issue(tag, 1'b0, f3, addr, 32'h0, rd);
        for (int i = 0; i < waits; i++) begin
            chk({tag, ".req_wait"}, {31'd0, bus.dmem_req_out}, 32'd1);
            chk({tag, ".addr_wait"}, bus.dmem_addr_out, exp_addr);
            chk({tag, ".stall_wait"}, {31'd0, bus.stall_out}, 32'd1);
            chk({tag, ".wb_wait"}, {31'd0, bus.wb_wr_en_out}, 32'd0);
            @(negedge clk);
        end
        chk({tag, ".req"}, {31'd0, bus.dmem_req_out}, 32'd1);
        chk({tag, ".addr"}, bus.dmem_addr_out, exp_addr);
        chk({tag, ".we"}, {31'd0, bus.dmem_we_out}, 32'd0);
        chk({tag, ".wmask"}, {28'd0, bus.dmem_wmask_out}, 32'd0);
        bus.dmem_ack_in   = 1'b1;
        bus.dmem_rdata_in = rdata;
        @(negedge clk);
        bus.dmem_ack_in   = 1'b0;
        bus.dmem_rdata_in = 32'h0;
        chk({tag, ".wb_en"}, {31'd0, bus.wb_wr_en_out}, {31'd0, exp_we});
        chk({tag, ".wb_rd_addr"}, {27'd0, bus.wb_rd_addr_out}, {27'd0, rd});
        chk({tag, ".wb_data"}, bus.wb_rd_out, exp_data);
        chk({tag, ".req_off"}, {31'd0, bus.dmem_req_out}, 32'd0);
        chk({tag, ".stall_wb"}, {31'd0, bus.stall_out}, 32'd1);
        @(negedge clk);
        chk({tag, ".wb_once"}, {31'd0, bus.wb_wr_en_out}, 32'd0);
        chk({tag, ".ready_again"}, {31'd0, bus.req_ready_out}, 32'd1);
    endtask

    task automatic run_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] data, input logic [31:0] exp_addr,
                             input logic [31:0] exp_wdata, input logic [3:0] exp_wmask);
        issue(tag, 1'b1, f3, addr, data, 5'd7);
        chk({tag, ".req"}, {31'd0, bus.dmem_req_out}, 32'd1);
        chk({tag, ".we"}, {31'd0, bus.dmem_we_out}, 32'd1);
        chk({tag, ".addr"}, bus.dmem_addr_out, exp_addr);
        chk({tag, ".wdata"}, bus.dmem_wdata_out, exp_wdata);
        chk({tag, ".wmask"}, {28'd0, bus.dmem_wmask_out}, {28'd0, exp_wmask});
        bus.dmem_ack_in = 1'b1;
        @(negedge clk);
        bus.dmem_ack_in = 1'b0;
        chk({tag, ".ready_again"}, {31'd0, bus.req_ready_out}, 32'd1);
        chk({tag, ".req_off"}, {31'd0, bus.dmem_req_out}, 32'd0);
        chk({tag, ".no_wb"}, {31'd0, bus.wb_wr_en_out}, 32'd0);
        chk({tag, ".stall_off"}, {31'd0, bus.stall_out}, 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        n_fail   = 0;
        rst                 = 1'b1;
        bus.req_valid_in    = 1'b0;
        bus.req_is_store_in = 1'b0;
        bus.funct3_in       = 3'd0;
        bus.addr_in         = 32'h0;
        bus.store_data_in   = 32'h0;
        bus.rd_addr_in      = 5'd0;
        bus.dmem_ack_in     = 1'b0;
        bus.dmem_rdata_in   = 32'h0;

        #3;
        chk("rst.ready", {31'd0, bus.req_ready_out}, 32'd1);
        chk("rst.req", {31'd0, bus.dmem_req_out}, 32'd0);
        chk("rst.we", {31'd0, bus.dmem_we_out}, 32'd0);
        chk("rst.addr", bus.dmem_addr_out, 32'd0);
        chk("rst.wdata", bus.dmem_wdata_out, 32'd0);
        chk("rst.wmask", {28'd0, bus.dmem_wmask_out}, 32'd0);
        chk("rst.wb_en", {31'd0, bus.wb_wr_en_out}, 32'd0);
        chk("rst.wb_addr", {27'd0, bus.wb_rd_addr_out}, 32'd0);
        chk("rst.wb_data", bus.wb_rd_out, 32'd0);
        chk("rst.stall", {31'd0, bus.stall_out}, 32'd0);
        chk("rst.misaligned", {31'd0, bus.misaligned_out}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Stray ack while idle must not start anything.
        bus.dmem_ack_in = 1'b1;
        @(negedge clk);
        bus.dmem_ack_in = 1'b0;
        chk("idle_ack.stall", {31'd0, bus.stall_out}, 32'd0);
        chk("idle_ack.wb_en", {31'd0, bus.wb_wr_en_out}, 32'd0);

        run_load("lb", 3'b000, 32'h0000_0103, 5'd5, 32'h80AA_BBCC, 0, 32'h0000_0100, 32'hFFFF_FF80, 1'b1);
        run_load("lbu", 3'b100, 32'h0000_0103, 5'd6, 32'h80AA_BBCC, 0, 32'h0000_0100, 32'h0000_0080, 1'b1);
        run_load("lb_lane1", 3'b000, 32'h0000_0041, 5'd9, 32'h1122_7F44, 0, 32'h0000_0040, 32'h0000_007F, 1'b1);
        run_load("lh_hi", 3'b001, 32'h0000_0302, 5'd10, 32'h8001_1234, 0, 32'h0000_0300, 32'hFFFF_8001, 1'b1);
        run_load("lhu_lo", 3'b101, 32'h0000_0300, 5'd11, 32'h8001_F234, 0, 32'h0000_0300, 32'h0000_F234, 1'b1);
        run_load("lw_rsvd", 3'b110, 32'h0000_0500, 5'd12, 32'hCAFE_F00D, 0, 32'h0000_0500, 32'hCAFE_F00D, 1'b1);

        run_store("sh", 3'b001, 32'h0000_0202, 32'h1234_ABCD, 32'h0000_0200, 32'hABCD_ABCD, 4'b1100);
        run_store("sb", 3'b000, 32'h0000_0201, 32'h0000_0055, 32'h0000_0200, 32'h5555_5555, 4'b0010);
        run_store("sw_rsvd", 3'b111, 32'h0000_0204, 32'h0BAD_CAFE, 32'h0000_0204, 32'h0BAD_CAFE, 4'b1111);

        run_load("lw_wait3", 3'b010, 32'h0000_1000, 5'd3, 32'hDEAD_BEEF, 3, 32'h0000_1000, 32'hDEAD_BEEF, 1'b1);
        run_load("lw_x0", 3'b010, 32'h0000_2000, 5'd0, 32'h1357_9BDF, 1, 32'h0000_2000, 32'h1357_9BDF, 1'b0);

        // Reset in the second BUSY cycle, then a late ack.
        issue("rst_mid", 1'b0, 3'b010, 32'h0000_3000, 32'h0, 5'd4);
        @(negedge clk);
        chk("rst_mid.req_before", {31'd0, bus.dmem_req_out}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid.req_drop", {31'd0, bus.dmem_req_out}, 32'd0);
        chk("rst_mid.stall_drop", {31'd0, bus.stall_out}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid.ready", {31'd0, bus.req_ready_out}, 32'd1);
        bus.dmem_ack_in   = 1'b1;
        bus.dmem_rdata_in = 32'h7777_7777;
        @(negedge clk);
        bus.dmem_ack_in   = 1'b0;
        chk("rst_mid.no_wb", {31'd0, bus.wb_wr_en_out}, 32'd0);
        chk("rst_mid.idle", {31'd0, bus.stall_out}, 32'd0);
        chk("rst_mid.wb_data", bus.wb_rd_out, 32'd0);
        @(negedge clk);
        chk("rst_mid.no_wb_late", {31'd0, bus.wb_wr_en_out}, 32'd0);

`ifdef MSRV32_LSU_MISALIGN_TRAP_EN
        issue("mis", 1'b0, 3'b010, 32'h0000_0101, 32'h0, 5'd8);
        chk("mis.pulse", {31'd0, bus.misaligned_out}, 32'd1);
        chk("mis.no_req", {31'd0, bus.dmem_req_out}, 32'd0);
        chk("mis.stall", {31'd0, bus.stall_out}, 32'd1);
        chk("mis.no_wb", {31'd0, bus.wb_wr_en_out}, 32'd0);
        @(negedge clk);
        chk("mis.pulse_end", {31'd0, bus.misaligned_out}, 32'd0);
        chk("mis.ready", {31'd0, bus.req_ready_out}, 32'd1);
        chk("mis.no_req2", {31'd0, bus.dmem_req_out}, 32'd0);
        chk("mis.no_wb2", {31'd0, bus.wb_wr_en_out}, 32'd0);
`else
        run_load("mis_lw", 3'b010, 32'h0000_0101, 5'd8, 32'h1122_3344, 0, 32'h0000_0100, 32'h1122_3344, 1'b1);
        chk("mis.never", {31'd0, bus.misaligned_out}, 32'd0);
`endif

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/msrv32_load_store_unit.md
# msrv32_load_store_unit

Multi-cycle load/store unit in pipeline stage 3, directly upstream of the integer register file's write port. It accepts one memory operation at a time from the stage-3 issue logic and runs a request/acknowledge transaction with the data memory. For loads, it aligns and sign- or zero-extends the returned word and presents a single-cycle write (rd address, write enable, data) to the integer file. While busy, it stalls the pipeline.

## Interface
- No parameters; data width is fixed at 32, register address width at 5.
- ms_riscv32_mp_clk_in  input  1  clock, rising edge
- ms_riscv32_mp_rst_in  input  1  reset, asynchronous, active-high
- req_valid_in  input  1  operation valid from issue
- req_ready_out  output  1  unit can accept (IDLE only)
- req_is_store_in  input  1  1 = store, 0 = load
- funct3_in  input  3  RV32I width/sign code
- addr_in  input  32  effective byte address
- store_data_in  input  32  rs2 value for stores
- rd_addr_in  input  5  load destination register
- dmem_req_out  output  1  memory request, held until ack
- dmem_we_out  output  1  1 = write
- dmem_addr_out  output  32  word address, {addr[31:2],2'b00}
- dmem_wdata_out  output  32  lane-replicated store data
- dmem_wmask_out  output  4  byte write strobes
- dmem_ack_in  input  1  memory done; rdata valid same cycle
- dmem_rdata_in  input  32  read word
- wb_rd_addr_out  output  5  to integer file rd_addr_in
- wb_wr_en_out  output  1  to integer file wr_en_in
- wb_rd_out  output  32  to integer file rd_in
- stall_out  output  1  high whenever state != IDLE
- misaligned_out  output  1  trap pulse (only with MSRV32_LSU_MISALIGN_TRAP_EN)

## Operation
- FSM states: IDLE, BUSY, WB, and TRAP (TRAP exists only with the macro).
- IDLE: req_ready_out=1. On req_valid_in, the unit registers all request fields and goes to BUSY, or to TRAP if the access is misaligned and the macro is on.
- BUSY: dmem_req_out=1. dmem_we/addr/wdata/wmask stay stable from registered fields. On dmem_ack_in, a store goes to IDLE. A load registers the extended data and goes to WB.
- WB: one cycle. wb_wr_en_out=1 only if rd != 0. wb_rd_addr_out=rd. Then the unit goes to IDLE.
- TRAP: one cycle. misaligned_out=1, no memory request, no writeback. Then the unit goes to IDLE.
- dmem_ack_in outside BUSY is ignored.
- funct3 for loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Reserved codes (011, 110, 111) act as LW.
- funct3 for stores: 000 SB, 001 SH, 010 SW. All other codes act as SW.
- Byte lane = addr[1:0]. Halfword lane = addr[1]. addr[0] is ignored for halfwords and addr[1:0] is ignored for words.
- Load extension: LB/LH sign-extend from the lane MSB. LBU/LHU zero-extend.
- Store data: SB puts {4{data[7:0]}} with wmask 4'b0001<<addr[1:0]. SH puts {2{data[15:0]}} with wmask 4'b0011<<{addr[1],1'b0}. SW puts data with wmask 4'b1111.
- Load requests drive wmask=0, we=0.
- Outputs are registered or decoded from state. There is no combinational path from the req_* inputs to the dmem_* outputs.

## Timing
- Accept at edge N. dmem_req_out is high from N+1. With ack sampled at edge M (M ≥ N+1), the load WB pulse is in cycle M+1 and req_ready_out is high again at M+2.
- Stores: req_ready_out is high again at M+1.
- Zero-wait memory (ack in the first BUSY cycle): a load takes 3 cycles from accept to next accept, a store 2.
- Reset values: all outputs 0 except req_ready_out=1. State is IDLE.
- Reset mid-operation: the transaction is dropped and dmem_req_out/wb_wr_en_out fall asynchronously. No writeback occurs for the dropped transaction.
- req_valid_in while not ready is not accepted. The issue side holds it until ready.

## Configuration
- MSRV32_LSU_MISALIGN_TRAP_EN defined:
  - Halfword with addr[0]=1, or word with addr[1:0]!=0, is misaligned.
  - A misaligned access goes IDLE→TRAP→IDLE with a 1-cycle misaligned_out pulse, no memory activity and no integer file write.
- Undefined:
  - misaligned_out is tied 0 and the TRAP state is absent.
  - Misaligned accesses proceed using the lane rules above (low address bits ignored).

## Test plan
- LB at 0x0000_0103, rdata 0x80AA_BBCC, zero-wait → dmem_addr 0x100, WB pulse with rd_out 0xFFFF_FF80 to the requested rd. LBU at the same address → 0x0000_0080.
- SH at 0x0000_0202, data 0x1234_ABCD → dmem_we=1, wmask 4'b1100, wdata 0xABCD_ABCD. No wb_wr_en. Ready 2 cycles after accept.
- LW with 3 wait cycles, rdata 0xDEAD_BEEF → dmem_req held 4 cycles with stable address, stall_out high throughout, single WB pulse of 0xDEAD_BEEF.
- LW to rd=0 → full memory transaction, wb_wr_en_out stays 0.
- Reset asserted in the 2nd BUSY cycle, ack arriving later → dmem_req drops immediately, no WB, ready=1 after reset release, stray ack ignored.
- LW at 0x0000_0101:
  - With the macro: misaligned_out 1-cycle pulse, dmem_req never asserted.
  - Without the macro: dmem_addr 0x100, normal load.
